// File: rtl/im_loader.sv
// Instruction-memory program loader: packs a big-endian byte stream into 32-bit words
// and writes them from BASE_ADDR upward. Define IM_LOADER_CHECKSUM_EN for a running word sum.
module im_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h00003000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] len_words,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);
    // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
    // depends only on state, never on in_valid.
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [13:0] DEPTH_LIM = 14'(DEPTH_WORDS);

    state_t      state, state_next;
    logic [12:0] len_q;
    logic [12:0] index_q;
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;
    logic        err_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;

    logic start_ok;
    logic len_bad;
    logic accept;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign len_bad  = {1'b0, len_words} > DEPTH_LIM;
    assign accept   = in_valid && (state == RECV);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    if (len_bad || len_words == 13'd0) state_next = DONE;
                    else                               state_next = RECV;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
                if (index_q + 13'd1 == len_q) state_next = DONE;
                else                          state_next = RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            index_q  <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
            err_q    <= 1'b0;
            waddr_q  <= BASE_ADDR;
            wdata_q  <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                len_q    <= len_words;
                index_q  <= '0;
                byte_cnt <= '0;
                err_q    <= len_bad;
            end
            // Address and word are captured together on the 4th byte so both stay
            // stable outside WRITE.
            if (accept) begin
                shift_q  <= {shift_q[15:0], in_byte};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    wdata_q <= {shift_q, in_byte};
                    waddr_q <= BASE_ADDR + {17'd0, index_q, 2'b00};
                end
            end
            if (state == WRITE) index_q <= index_q + 13'd1;
        end
    end

    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign err   = err_q;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset)               sum_q <= '0;
        else if (start_ok)       sum_q <= '0;
        else if (state == WRITE) sum_q <= sum_q + wdata_q;
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: random and directed loads checked against a word-list model
// through an expected-write scoreboard.
module tb_im_loader;
    localparam logic [31:0] BASE = 32'h00003000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] len_words;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    im_loader dut (
        .clk(clk), .reset(reset), .start(start), .len_words(len_words),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .checksum(checksum)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] fixed_w[$];
    logic [31:0] exp_sum;
    int          we_cyc[$];
    int          n_we = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] last_waddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (we) begin
            n_we++;
            we_cyc.push_back(cyc);
            last_waddr = waddr;
            if (exp_addr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_we: got waddr %h wdata %h, expected no write", waddr, wdata);
            end else begin
                check("waddr", waddr, exp_addr_q.pop_front());
                check("wdata", wdata, exp_data_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] exp_checksum();
`ifdef IM_LOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 32'd0;
`endif
    endfunction

    // driver tasks
    task automatic do_start(input int len);
        @(posedge clk); #1;
        start     = 1'b1;
        len_words = 13'(len);
        start_cyc = cyc;
        exp_sum   = '0;
        n_we      = 0;
        we_cyc.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit in_word);
        bit ok = 1'b0;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (in_word) check("in_ready_gap", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: got in_ready=0 for 50 cycles, expected 1");
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, expected 1", budget);
        end
    endtask

    // model: words in order, byte address BASE+4*i, big-endian bytes on the wire
    task automatic build_words(input int len, input bit use_fixed, output logic [7:0] bq[$]);
        logic [31:0] w;
        bq.delete();
        for (int i = 0; i < len; i++) begin
            w = use_fixed ? fixed_w[i] : $urandom();
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_data_q.push_back(w);
            exp_sum += w;
            bq.push_back(w[31:24]);
            bq.push_back(w[23:16]);
            bq.push_back(w[15:8]);
            bq.push_back(w[7:0]);
        end
    endtask

    task automatic finish_checks(input int len);
        check("done", {31'd0, done}, 32'd1);
        check("err", {31'd0, err}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("checksum", checksum, exp_checksum());
        check("queue_empty", 32'(exp_addr_q.size()), 32'd0);
        check("we_count", 32'(n_we), 32'(len));
    endtask

    task automatic load_words(input int len, input int gmin, input int gmax, input bit use_fixed);
        logic [7:0] bq[$];
        do_start(len);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("busy_recv", {31'd0, busy}, 32'd1);
        exp_sum = '0;
        build_words(len, use_fixed, bq);
        for (int i = 0; i < bq.size(); i++)
            send_byte(bq[i], $urandom_range(gmax, gmin), (i % 4) != 0);
        wait_done(len * 5 * (gmax + 1) + 100);
        finish_checks(len);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, we}, 32'd0);
        check({tag, "_waddr"}, waddr, BASE);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        logic [7:0] bq[$];
        reset = 1'b1; start = 1'b0; len_words = '0; in_valid = 1'b0; in_byte = '0;
        exp_sum = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("rst");

        // directed image, continuous stream, cycle timing
        fixed_w.delete();
        fixed_w.push_back(32'h24010005);
        fixed_w.push_back(32'h00000008);
        load_words(2, 0, 0, 1'b1);
        check("we0_cycle", 32'(we_cyc.size() > 0 ? we_cyc[0] - start_cyc : -1), 32'd5);
        check("we1_cycle", 32'(we_cyc.size() > 1 ? we_cyc[1] - start_cyc : -1), 32'd10);
        check("done_cycle", 32'(done_cyc - start_cyc), 32'd11);

        // bytes offered in DONE are not consumed
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        // same image with 3-cycle gaps
        load_words(2, 3, 3, 1'b1);

        // zero-length and oversize requests
        do_start(0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_err", {31'd0, err}, 32'd0);
        do_start(4097);
        check("big_done", {31'd0, done}, 32'd1);
        check("big_err", {31'd0, err}, 32'd1);
        check("big_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1 check("no_we_len0_big", 32'(n_we), 32'd0);

        // reset mid-load after two bytes of word 1
        do_start(3);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_reset_vals("midrst");
        check("midrst_no_we", 32'(n_we), 32'd0);
        load_words(1, 0, 1, 1'b0);

        // start pulsed during RECV is ignored
        do_start(2);
        exp_sum = '0;
        build_words(2, 1'b0, bq);
        for (int i = 0; i < bq.size(); i++) begin
            if (i == 2) begin
                start = 1'b1;
                len_words = 13'd1;
            end
            send_byte(bq[i], 0, (i % 4) != 0);
            start = 1'b0;
        end
        wait_done(100);
        finish_checks(2);
        load_words(1, 0, 0, 1'b0);

        // random loads
        for (int t = 0; t < 6; t++)
            load_words($urandom_range(8, 1), 0, $urandom_range(2, 0), 1'b0);

        // full-depth load
        load_words(4096, 0, 0, 1'b0);
        check("last_waddr", last_waddr, 32'h00006FFC);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
